// File: rtl/vx_tcu_seq_pkg.sv
// Shared types and format helpers for the TCU FEDP issue sequencer.
package vx_tcu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

  localparam logic [2:0] TCU_FMT_FP16 = 3'd2;
  localparam logic [2:0] TCU_FMT_BF16 = 3'd3;

  function automatic logic fmt_supported(input logic [2:0] fmt);
    return (fmt == TCU_FMT_FP16) || (fmt == TCU_FMT_BF16);
  endfunction

endpackage

// File: rtl/vx_tcu_seq_timer.sv
// Loadable down-counter timing the FEDP drain window; last = count 1, active = count > 1.
module vx_tcu_seq_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             tick,
  output logic             last,
  output logic             active
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last   = (count_q == WIDTH'(1));
  assign active = (count_q > WIDTH'(1));

endmodule

// File: rtl/vx_tcu_fedp_seq.sv
// Issue-side sequencer for the tensor-core FEDP: streams K operand beats, chaining results as C.
// Optional VX_TCU_SEQ_PERF_EN adds busy / operand-stall cycle counters.
module vx_tcu_fedp_seq
  import vx_tcu_seq_pkg::*;
#(
  parameter int unsigned N            = 2,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FEDP_LATENCY = 4,
  parameter int unsigned KW           = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KW-1:0]       req_k,
  input  logic [XLEN-1:0]     req_c,
  input  logic [2:0]          req_fmt_s,
  input  logic [2:0]          req_fmt_d,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [N*XLEN-1:0]   op_a_row,
  input  logic [N*XLEN-1:0]   op_b_col,
  output logic                fedp_enable,
  output logic [2:0]          fedp_fmt_s,
  output logic [2:0]          fedp_fmt_d,
  output logic [N*XLEN-1:0]   fedp_a_row,
  output logic [N*XLEN-1:0]   fedp_b_col,
  output logic [XLEN-1:0]     fedp_c_val,
  input  logic [XLEN-1:0]     fedp_d_val,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_d,
  output logic                rsp_err
`ifdef VX_TCU_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_op_stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(FEDP_LATENCY + 1);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [KW-1:0]   step_q, step_d;
  logic [KW-1:0]   k_q, k_d;
  logic [2:0]      fmt_s_q, fmt_s_d;
  logic [2:0]      fmt_d_q, fmt_d_d;
  logic [XLEN-1:0] rsp_d_q, rsp_d_d;
  logic            rsp_err_q, rsp_err_d;
  logic            timer_load, timer_last, timer_active;

  vx_tcu_seq_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (CW'(FEDP_LATENCY)),
    .tick    (state_q == ST_WAIT),
    .last    (timer_last),
    .active  (timer_active)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    step_d      = step_q;
    k_d         = k_q;
    fmt_s_d     = fmt_s_q;
    fmt_d_d     = fmt_d_q;
    rsp_d_d     = rsp_d_q;
    rsp_err_d   = rsp_err_q;
    timer_load  = 1'b0;
    req_ready   = 1'b0;
    op_ready    = 1'b0;
    fedp_enable = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // state_q already reads IDLE while reset is held, so gate the ready explicitly
        req_ready = reset_n;
        if (req_valid) begin
          k_d     = req_k;
          fmt_s_d = req_fmt_s;
          fmt_d_d = req_fmt_d;
          acc_d   = req_c;
          step_d  = '0;
          if (!fmt_supported(req_fmt_s)) begin
            rsp_err_d = 1'b1;
            rsp_d_d   = '0;
            state_d   = ST_DONE;
          end else if (req_k == '0) begin
            rsp_d_d = req_c;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        op_ready    = 1'b1;
        fedp_enable = op_valid;
        if (op_valid) begin
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        fedp_enable = timer_active;
        if (timer_last) begin
          acc_d  = fedp_d_val;
          step_d = step_q + KW'(1);
          if (step_d == k_q) begin
            rsp_d_d = fedp_d_val;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      step_q    <= '0;
      k_q       <= '0;
      fmt_s_q   <= '0;
      fmt_d_q   <= '0;
      rsp_d_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      k_q       <= k_d;
      fmt_s_q   <= fmt_s_d;
      fmt_d_q   <= fmt_d_d;
      rsp_d_q   <= rsp_d_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign fedp_fmt_s = fmt_s_q;
  assign fedp_fmt_d = fmt_d_q;
  assign fedp_a_row = op_a_row;
  assign fedp_b_col = op_b_col;
  assign fedp_c_val = acc_q;
  assign rsp_d      = rsp_d_q;
  assign rsp_err    = rsp_err_q;

`ifdef VX_TCU_SEQ_PERF_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if ((state_q != ST_IDLE) && (busy_q != '1)) begin
      busy_d = busy_q + 32'd1;
    end
    if ((state_q == ST_ISSUE) && !op_valid && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cycles     = busy_q;
  assign perf_op_stall_cycles = stall_q;
`endif

endmodule

// File: doc/vx_tcu_fedp_seq.md
Name: vx_tcu_fedp_seq

Overview:
- Issue-side sequencer for the tensor-core fused dot-product (FEDP) unit.
- Accepts one dot-product job: initial accumulator C, K-step count and formats.
- Streams K operand beats (N packed XLEN words of A row and B column) into the FEDP, chaining each FEDP result back as the next C.
- Returns the final accumulated value on a valid/ready response port.
- Sits between the TCU operand collector and the FEDP instance; one job in flight at a time.

Parameters:
- N, 2, XLEN words per operand row/column (each word = two 16-bit elements)
- XLEN, 32, word width
- FEDP_LATENCY, 4, FEDP enabled-cycle latency (must match the instantiated FEDP; ≥1)
- KW, 4, width of the K-step count

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  job request valid
- req_ready  out  1  job request ready
- req_k  in  KW  number of K steps
- req_c  in  XLEN  initial accumulator (fp32 in [31:0])
- req_fmt_s  in  3  source format
- req_fmt_d  in  3  destination format
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat ready
- op_a_row  in  N*XLEN  A operands
- op_b_col  in  N*XLEN  B operands
- fedp_enable  out  1  FEDP pipeline advance
- fedp_fmt_s  out  3  to FEDP
- fedp_fmt_d  out  3  to FEDP
- fedp_a_row  out  N*XLEN  to FEDP
- fedp_b_col  out  N*XLEN  to FEDP
- fedp_c_val  out  XLEN  to FEDP
- fedp_d_val  in  XLEN  from FEDP
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_d  out  XLEN  final accumulator
- rsp_err  out  1  unsupported source format

Behaviour:
- Reset (async assert, sync deassert by the caller): state IDLE; acc, step counter, wait counter, rsp_d, rsp_err = 0. All valid and ready outputs and fedp_enable = 0. A reset mid-job abandons the job; FEDP contents are don't-care.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready = 1.
  - On req fire: latch k, fmt_s, fmt_d; acc <= req_c.
  - If fmt_s not in {2 (FP16), 3 (BF16)}: go to DONE with rsp_err = 1, rsp_d = 0.
  - Else if req_k == 0: go to DONE with rsp_d = req_c.
  - Else: go to ISSUE with step = 0.
- ISSUE:
  - op_ready = 1.
  - fedp_a_row/b_col = op_a_row/op_b_col; fedp_c_val = acc; fmt outputs = latched values.
  - fedp_enable = op_valid & op_ready.
  - On op fire in cycle T: wait counter <= FEDP_LATENCY; go to WAIT.
  - No fire: hold, fedp_enable = 0.
- WAIT:
  - Occupies cycles T+1..T+FEDP_LATENCY.
  - fedp_enable = 1 while counter > 1; 0 in the final cycle. This gives exactly FEDP_LATENCY enabled edges, including T.
  - Counter decrements each cycle.
  - In the cycle where counter == 1: acc <= fedp_d_val; step <= step + 1. If step + 1 == k go to DONE, else go to ISSUE.
  - op_ready = 0 throughout.
- DONE:
  - rsp_valid = 1; rsp_d = acc, or 0 on error.
  - On rsp fire: go to IDLE; rsp_err <= 0.
  - rsp_valid must not drop until fire. rsp_d/rsp_err stable while valid.
- fedp_* data outputs are don't-care whenever fedp_enable = 0.
- req_ready is 0 outside IDLE. A new request is never accepted in the same cycle as rsp fire; IDLE takes ≥1 cycle.
- Step counter width KW; req_k = 2^KW−1 is the maximum and must not wrap.
- Throughput per job: k × (FEDP_LATENCY + 1) + 2 cycles minimum.

Optional Feature:
- VX_TCU_SEQ_PERF_EN defined: adds outputs perf_busy_cycles (32) and perf_op_stall_cycles (32).
  - perf_busy_cycles increments every cycle state ≠ IDLE.
  - perf_op_stall_cycles increments every ISSUE cycle with op_valid = 0.
  - Both saturate at 2^32−1 and reset to 0.
- Undefined: ports and counters absent; no other behavioural difference.

Decomposition:
- Package vx_tcu_seq_pkg: state enum (IDLE/ISSUE/WAIT/DONE), format constants TCU_FMT_FP16 = 3'd2 and TCU_FMT_BF16 = 3'd3, function fmt_supported(fmt).
- One sub-module, vx_tcu_seq_timer: loadable down-counter. Inputs load, value, tick; outputs last (count == 1) and active (count > 1). It drives the WAIT timing and fedp_enable.

Test Plan:
- FP16, N=2, k=1, all A halves 0x3C00, all B halves 0x4000, C=0x3F800000 → rsp_d=0x41100000 (9.0). fedp_enable high exactly 4 cycles; rsp_valid 5 cycles after op fire.
- Same operands, k=2, C=0x3F800000 → second issue carries fedp_c_val=0x41100000; rsp_d=0x41880000 (17.0).
- req_k=0, C=0x40400000 → no fedp_enable pulse; rsp_d=0x40400000 one cycle after req fire.
- req_fmt_s=3'd5 → rsp_err=1, rsp_d=0, no op_ready; after rsp fire rsp_err=0.
- k=3 with op_valid withheld 3 cycles before beat 2, and rsp_ready held low 4 cycles → no spurious fedp_enable; result unchanged; rsp_valid/rsp_d stable while stalled.
- Assert reset_n mid-WAIT → outputs 0 in the same cycle; next job after release completes correctly.
